// File: rtl/dynamixel_pkg.sv
// Shared constants, FSM state type and byte-level helpers for the Dynamixel
// Protocol 2.0 Sync Write transmitter.
package dynamixel_pkg;

  localparam logic [7:0]  BROADCAST_ID     = 8'hFE;
  localparam logic [7:0]  INSTR_SYNC_WRITE = 8'h83;
  localparam logic [15:0] CRC_POLY         = 16'h8005;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HEADER     = 3'd1,
    ST_PREFIX     = 3'd2,
    ST_SERVO_ID   = 3'd3,
    ST_SERVO_DATA = 3'd4,
    ST_CRC        = 3'd5
  } dxl_state_e;

  function automatic logic [7:0] header_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'hFF;
      2'd1:    b = 8'hFF;
      2'd2:    b = 8'hFD;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // MSB-first CRC-16/0x8005 advanced by one whole byte
  function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] packet_len(input logic [15:0] count, input logic [15:0] dlen);
    return count * (dlen + 16'd1) + 16'd7;
  endfunction

endpackage

// File: rtl/dynamixel_sync_writer_n_if.sv
// Request/status bundle between the robot top level and the Sync Write transmitter.
interface dynamixel_sync_writer_n_if #(
  parameter int MAX_SERVOS = 8
);
  localparam int CW = $clog2(MAX_SERVOS + 1);

  logic                      send;
  logic [15:0]               address;
  logic [2:0]                data_len;
  logic [CW-1:0]             servo_count;
  logic [8*MAX_SERVOS-1:0]   ids;
  logic [32*MAX_SERVOS-1:0]  values;
  logic                      busy;
  logic                      sending;
  logic                      pin;
  logic                      done;
  logic                      error;

  modport master (
    output send, address, data_len, servo_count, ids, values,
    input  busy, sending, pin, done, error
  );

  modport slave (
    input  send, address, data_len, servo_count, ids, values,
    output busy, sending, pin, done, error
  );
endinterface

// File: rtl/dynamixel_sync_writer_n_uart_tx_byte.sv
// 8N1 byte serialiser; ready rises in the last cycle of the stop bit so the
// next byte can be loaded with no idle gap.
module uart_tx_byte #(
  parameter int CLOCKS_PER_BIT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       ready_o,
  output logic       pin_o
);
  localparam int             BW        = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);

  logic          active_q, active_d;
  logic          pin_q, pin_d;
  logic [8:0]    frame_q, frame_d;
  logic [3:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          bit_end_s;

  assign bit_end_s = (baud_q == BAUD_LAST);
  assign ready_o   = !active_q || (bit_end_s && (bit_q == 4'd9));
  assign pin_o     = pin_q;

  // bit sequencing: the start bit goes out on the load edge, stop bit ends the frame
  always_comb begin
    active_d = active_q;
    pin_d    = pin_q;
    frame_d  = frame_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    if (load_i && ready_o) begin
      active_d = 1'b1;
      pin_d    = 1'b0;
      frame_d  = {1'b1, byte_i};
      bit_d    = 4'd0;
      baud_d   = {BW{1'b0}};
    end else if (active_q) begin
      if (bit_end_s) begin
        baud_d = {BW{1'b0}};
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          pin_d    = 1'b1;
        end else begin
          pin_d   = frame_q[0];
          frame_d = {1'b1, frame_q[8:1]};
          bit_d   = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + BW'(1);
      end
    end else begin
      pin_d = 1'b1;
    end
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= 1'b0;
      pin_q    <= 1'b1;
      frame_q  <= 9'h1FF;
      bit_q    <= 4'd0;
      baud_q   <= {BW{1'b0}};
    end else begin
      active_q <= active_d;
      pin_q    <= pin_d;
      frame_q  <= frame_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
    end
  end
endmodule

// File: rtl/dynamixel_sync_writer_n.sv
// Dynamixel 2.0 Sync Write transmitter: latches a request, walks header, prefix,
// per-servo ID/data and CRC bytes, and streams them through a gapless 8N1 UART.
module dynamixel_sync_writer_n
  import dynamixel_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 3,
  parameter int MAX_SERVOS     = 8
) (
  input logic                      clock,
  input logic                      reset,
  dynamixel_sync_writer_n_if.slave bus
);
  localparam int CW = $clog2(MAX_SERVOS + 1);
  localparam int SW = (MAX_SERVOS > 1) ? $clog2(MAX_SERVOS) : 1;

  dxl_state_e    state_q, state_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [SW-1:0] servo_idx_q, servo_idx_d;
  logic [15:0]   crc_q, crc_d;
  logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [15:0]   addr_q;
  logic [2:0]    dlen_q;
  logic [CW-1:0] count_q;
  logic [7:0]    ids_q  [MAX_SERVOS];
  logic [31:0]   vals_q [MAX_SERVOS];
  logic          latch_s, legal_s, load_s, tx_ready_s, tx_pin_s;
  logic [7:0]    byte_s, tx_byte_s;
  logic [15:0]   len_s;
  logic [31:0]   cur_val_s;

  assign len_s   = packet_len(16'(count_q), 16'(dlen_q));
  assign legal_s = (bus.data_len != 3'd0) && (bus.data_len <= 3'd4) &&
                   (bus.servo_count != {CW{1'b0}}) && (bus.servo_count <= CW'(MAX_SERVOS));

  // byte that belongs at the current packet position
  always_comb begin
    byte_s    = 8'hFF;
    cur_val_s = vals_q[servo_idx_q];
    case (state_q)
      ST_HEADER: byte_s = header_byte(byte_idx_q[1:0]);
      ST_PREFIX: begin
        case (byte_idx_q[2:0])
          3'd0:    byte_s = BROADCAST_ID;
          3'd1:    byte_s = len_s[7:0];
          3'd2:    byte_s = len_s[15:8];
          3'd3:    byte_s = INSTR_SYNC_WRITE;
          3'd4:    byte_s = addr_q[7:0];
          3'd5:    byte_s = addr_q[15:8];
          3'd6:    byte_s = {5'd0, dlen_q};
          default: byte_s = 8'h00;
        endcase
      end
      ST_SERVO_ID: byte_s = ids_q[servo_idx_q];
      ST_SERVO_DATA: begin
        case (byte_idx_q[1:0])
          2'd0:    byte_s = cur_val_s[7:0];
          2'd1:    byte_s = cur_val_s[15:8];
          2'd2:    byte_s = cur_val_s[23:16];
          default: byte_s = cur_val_s[31:24];
        endcase
      end
      ST_CRC:  byte_s = byte_idx_q[0] ? crc_q[15:8] : crc_q[7:0];
      default: byte_s = 8'hFF;
    endcase
  end

  // FSM next state: every step loads one byte when the UART is ready
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    servo_idx_d = servo_idx_q;
    crc_d       = crc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    latch_s     = 1'b0;
    load_s      = 1'b0;
    tx_byte_s   = byte_s;
    case (state_q)
      ST_IDLE: begin
        if (bus.send && legal_s) begin
          latch_s     = 1'b1;
          load_s      = 1'b1;
          tx_byte_s   = header_byte(2'd0);
          crc_d       = crc16_update(16'h0000, header_byte(2'd0));
          byte_idx_d  = 4'd1;
          servo_idx_d = {SW{1'b0}};
          busy_d      = 1'b1;
          state_d     = ST_HEADER;
        end else begin
          error_d = bus.send;
        end
      end
      ST_HEADER: begin
        if (tx_ready_s) begin
          load_s = 1'b1;
          crc_d  = crc16_update(crc_q, byte_s);
          if (byte_idx_q == 4'd3) begin
            byte_idx_d = 4'd0;
            state_d    = ST_PREFIX;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_PREFIX: begin
        if (tx_ready_s) begin
          load_s = 1'b1;
          crc_d  = crc16_update(crc_q, byte_s);
          if (byte_idx_q == 4'd7) begin
            byte_idx_d  = 4'd0;
            servo_idx_d = {SW{1'b0}};
            state_d     = ST_SERVO_ID;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_SERVO_ID: begin
        if (tx_ready_s) begin
          load_s     = 1'b1;
          crc_d      = crc16_update(crc_q, byte_s);
          byte_idx_d = 4'd0;
          state_d    = ST_SERVO_DATA;
        end else begin
          state_d = state_q;
        end
      end
      ST_SERVO_DATA: begin
        if (tx_ready_s) begin
          load_s = 1'b1;
          crc_d  = crc16_update(crc_q, byte_s);
          if (byte_idx_q[2:0] != dlen_q - 3'd1) begin
            byte_idx_d = byte_idx_q + 4'd1;
          end else if (servo_idx_q == SW'(count_q - CW'(1))) begin
            byte_idx_d = 4'd0;
            state_d    = ST_CRC;
          end else begin
            servo_idx_d = servo_idx_q + SW'(1);
            state_d     = ST_SERVO_ID;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_CRC: begin
        // index 2 only waits for the CRC_H stop bit to finish
        if (tx_ready_s) begin
          if (byte_idx_q == 4'd2) begin
            byte_idx_d = 4'd0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            load_s     = 1'b1;
            byte_idx_d = byte_idx_q + 4'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and status registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_idx_q  <= 4'd0;
      servo_idx_q <= {SW{1'b0}};
      crc_q       <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      servo_idx_q <= servo_idx_d;
      crc_q       <= crc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // request capture so later input changes cannot disturb the packet in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= 16'h0000;
      dlen_q  <= 3'd0;
      count_q <= {CW{1'b0}};
      for (int k = 0; k < MAX_SERVOS; k++) begin
        ids_q[k]  <= 8'h00;
        vals_q[k] <= 32'h0000_0000;
      end
    end else if (latch_s) begin
      addr_q  <= bus.address;
      dlen_q  <= bus.data_len;
      count_q <= bus.servo_count;
      for (int k = 0; k < MAX_SERVOS; k++) begin
        ids_q[k]  <= bus.ids[8*k +: 8];
        vals_q[k] <= bus.values[32*k +: 32];
      end
    end
  end

  uart_tx_byte #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_tx (
    .clock  (clock),
    .reset  (reset),
    .load_i (load_s),
    .byte_i (tx_byte_s),
    .ready_o(tx_ready_s),
    .pin_o  (tx_pin_s)
  );

  assign bus.pin     = tx_pin_s;
  assign bus.busy    = busy_q;
  assign bus.sending = busy_q;
  assign bus.done    = done_q;
  assign bus.error   = error_q;
endmodule

// File: tb/tb_dynamixel_sync_writer_n.sv
// Directed bench for the Sync Write transmitter: a packet-level model predicts the
// pin waveform and status outputs every cycle; literal expectations pin the model.
module tb_dynamixel_sync_writer_n;
  localparam int CPB  = 3;
  localparam int MAXS = 8;

  logic clock;
  logic reset;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  dynamixel_sync_writer_n_if #(.MAX_SERVOS(MAXS)) bus ();

  dynamixel_sync_writer_n #(
    .CLOCKS_PER_BIT(CPB),
    .MAX_SERVOS    (MAXS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // model of the packet in flight
  logic [7:0]  exp_bytes[$];
  int          exp_start   = 0;
  int          exp_end     = 0;
  int          exp_done_at = -1;
  int          exp_err_at  = -1;
  logic [7:0]  t_ids  [MAXS];
  logic [31:0] t_vals [MAXS];
  bit          cmp_en = 1'b0;
  bit          in_pkt;
  int          busy_cnt = 0, done_cnt = 0, err_cnt = 0, send_cnt = 0, low_cnt = 0;
  int          b0, d0, e0, s0, l0;

  logic [7:0]  golden1 [24] = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'hFE, 8'h11, 8'h00, 8'h83,
                                 8'h74, 8'h00, 8'h04, 8'h00, 8'h01, 8'h96, 8'h00, 8'h00,
                                 8'h00, 8'h02, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h82, 8'h87};

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_pin(input int c);
    int k, b, bt;
    logic [7:0] v;
    k  = (c - exp_start) / CPB;
    b  = k / 10;
    bt = k % 10;
    if (bt == 0) return 1'b0;
    if (bt == 9) return 1'b1;
    v = exp_bytes[b];
    return v[bt-1];
  endfunction

  // packet built straight from the protocol rules, CRC computed bit-serially
  task automatic build_model(input logic [15:0] a, input int dl, input int cnt);
    logic [15:0] len, crc;
    logic [7:0]  v;
    logic [31:0] w;
    exp_bytes = {};
    len = 16'(cnt * (1 + dl) + 7);
    exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'hFF);
    exp_bytes.push_back(8'hFD); exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'hFE);
    exp_bytes.push_back(len[7:0]); exp_bytes.push_back(len[15:8]);
    exp_bytes.push_back(8'h83);
    exp_bytes.push_back(a[7:0]); exp_bytes.push_back(a[15:8]);
    exp_bytes.push_back(8'(dl)); exp_bytes.push_back(8'h00);
    for (int k = 0; k < cnt; k++) begin
      exp_bytes.push_back(t_ids[k]);
      w = t_vals[k];
      for (int j = 0; j < dl; j++) exp_bytes.push_back(w[8*j +: 8]);
    end
    crc = 16'h0000;
    foreach (exp_bytes[i]) begin
      v = exp_bytes[i];
      for (int bi = 7; bi >= 0; bi--) begin
        if (crc[15] ^ v[bi]) crc = {crc[14:0], 1'b0} ^ 16'h8005;
        else                 crc = {crc[14:0], 1'b0};
      end
    end
    exp_bytes.push_back(crc[7:0]);
    exp_bytes.push_back(crc[15:8]);
  endtask

  task automatic do_send(input logic [15:0] a, input int dl, input int cnt);
    @(posedge clock); #2;
    bus.address     = a;
    bus.data_len    = 3'(dl);
    bus.servo_count = 4'(cnt);
    for (int k = 0; k < MAXS; k++) begin
      bus.ids[8*k +: 8]     = t_ids[k];
      bus.values[32*k +: 32] = t_vals[k];
    end
    bus.send = 1'b1;
    if (!(cyc >= exp_start && cyc < exp_end)) begin
      if (dl >= 1 && dl <= 4 && cnt >= 1 && cnt <= MAXS) begin
        build_model(a, dl, cnt);
        exp_start   = cyc + 1;
        exp_end     = exp_start + 10 * CPB * exp_bytes.size();
        exp_done_at = exp_end;
      end else begin
        exp_err_at = cyc + 1;
      end
    end
    @(posedge clock); #2;
    bus.send = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    if (exp_end > cyc + 1) exp_end = cyc + 1;
    if (exp_done_at > cyc) exp_done_at = -1;
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_pin", bus.pin, 1);
    chk("rst_sending", bus.sending, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  task automatic wait_pkt();
    repeat (exp_end - cyc + 4) @(posedge clock);
    #2;
  endtask

  task automatic snap();
    b0 = busy_cnt; d0 = done_cnt; e0 = err_cnt; s0 = send_cnt; l0 = low_cnt;
  endtask

  // per-cycle compare against the model
  always @(negedge clock) begin
    if (cmp_en) begin
      in_pkt = (cyc >= exp_start) && (cyc < exp_end);
      chk("busy", bus.busy, in_pkt);
      chk("sending", bus.sending, in_pkt);
      chk("pin", bus.pin, in_pkt ? exp_pin(cyc) : 1'b1);
      chk("done", bus.done, cyc == exp_done_at);
      chk("error", bus.error, cyc == exp_err_at);
      busy_cnt += bus.busy;
      done_cnt += bus.done;
      err_cnt  += bus.error;
      send_cnt += bus.sending;
      low_cnt  += !bus.pin;
    end
  end

  initial begin
    reset           = 1'b1;
    bus.send        = 1'b0;
    bus.address     = 16'h0000;
    bus.data_len    = 3'd0;
    bus.servo_count = 4'd0;
    bus.ids         = '0;
    bus.values      = '0;
    for (int k = 0; k < MAXS; k++) begin
      t_ids[k]  = 8'h00;
      t_vals[k] = 32'h0;
    end
    repeat (3) @(posedge clock);
    #2;
    reset  = 1'b0;
    cmp_en = 1'b1;
    @(negedge clock);
    chk("reset_busy", bus.busy, 0);
    chk("reset_pin", bus.pin, 1);
    chk("reset_done", bus.done, 0);
    chk("reset_error", bus.error, 0);

    // reference packet from the protocol manual
    t_ids[0] = 8'd1; t_vals[0] = 32'd150;
    t_ids[1] = 8'd2; t_vals[1] = 32'd170;
    snap();
    do_send(16'd116, 4, 2);
    chk("t1_size", exp_bytes.size(), 24);
    for (int i = 0; i < 24; i++) chk("t1_model_byte", exp_bytes[i], golden1[i]);
    wait_pkt();
    chk("t1_busy_cycles", busy_cnt - b0, 720);
    chk("t1_done_count", done_cnt - d0, 1);

    // one value byte per servo
    for (int k = 0; k < 4; k++) begin
      t_ids[k]  = 8'(k + 1);
      t_vals[k] = 32'd1;
    end
    snap();
    do_send(16'd64, 1, 4);
    chk("t2_size", exp_bytes.size(), 22);
    chk("t2_len", {exp_bytes[6], exp_bytes[5]}, 16'h000F);
    wait_pkt();
    chk("t2_busy_cycles", busy_cnt - b0, 660);
    chk("t2_done_count", done_cnt - d0, 1);

    // illegal requests
    snap();
    do_send(16'd10, 0, 2);
    repeat (2) @(posedge clock);
    do_send(16'd10, 5, 2);
    repeat (2) @(posedge clock);
    do_send(16'd10, 2, 0);
    repeat (4) @(posedge clock);
    chk("t3_errors", err_cnt - e0, 3);
    chk("t3_sending", send_cnt - s0, 0);
    chk("t3_pin_low", low_cnt - l0, 0);

    // send while busy is ignored; inputs scrambled after accept
    for (int k = 0; k < 3; k++) begin
      t_ids[k]  = 8'(8'h10 + k);
      t_vals[k] = 32'h1122_3344 + 32'(k);
    end
    snap();
    do_send(16'h0123, 2, 3);
    repeat (40) @(posedge clock);
    for (int k = 0; k < 3; k++) t_vals[k] = 32'hCAFE_0000 + 32'(k);
    do_send(16'h0456, 4, 3);
    bus.values = '1;
    bus.ids    = '0;
    wait_pkt();
    chk("t4_done_count", done_cnt - d0, 1);
    chk("t4_errors", err_cnt - e0, 0);
    chk("t4_busy_cycles", busy_cnt - b0, 10 * CPB * (14 + 3 * 3));

    // reset mid-packet, then a clean packet
    t_ids[0] = 8'd5; t_vals[0] = 32'h00AB_CDEF;
    t_ids[1] = 8'd6; t_vals[1] = 32'h0012_3456;
    snap();
    do_send(16'h0200, 3, 2);
    repeat (10 * 10 * CPB) @(posedge clock);
    do_reset();
    repeat (20) @(posedge clock);
    chk("t5_no_done", done_cnt - d0, 0);
    snap();
    do_send(16'h0200, 3, 2);
    wait_pkt();
    chk("t5_done_count", done_cnt - d0, 1);
    chk("t5_busy_cycles", busy_cnt - b0, 10 * CPB * 22);

    // full servo count
    for (int k = 0; k < MAXS; k++) begin
      t_ids[k]  = 8'(8'h20 + k);
      t_vals[k] = 32'h1357_9BDF ^ (32'(k) << 4);
    end
    snap();
    do_send(16'h0074, 4, MAXS);
    chk("t6_size", exp_bytes.size(), 14 + 5 * MAXS);
    wait_pkt();
    chk("t6_busy_cycles", busy_cnt - b0, 10 * CPB * (14 + 5 * MAXS));
    chk("t6_done_count", done_cnt - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dynamixel_sync_writer_n.md
# dynamixel_sync_writer_n

Parametrised Dynamixel Protocol 2.0 Sync Write transmitter for up to MAX_SERVOS servos with 1–4 data bytes each. It assembles the complete packet (header, length, instruction, parameters, CRC-16), serialises it as 8N1 UART, and drives the half-duplex direction enable. It sits between the robot top level and the tri-stated `dynamixel` pin. It replaces the fixed four-servo writer and adds runtime servo count, per-servo IDs, CRC generation, error reporting and a completion strobe.

## Interface
- CLOCKS_PER_BIT, 3, clock cycles per UART bit (clock_frequency / dynamixel_baudrate); must be ≥ 1
- MAX_SERVOS, 8, maximum servos per packet; 1–32
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- send  in  1  one-cycle request; accepted only while busy=0
- address  in  16  control-table start address
- data_len  in  3  bytes per servo; legal values 1–4
- servo_count  in  $clog2(MAX_SERVOS+1)  servos in this packet; legal values 1–MAX_SERVOS
- ids  in  8*MAX_SERVOS  servo k ID at [8k+7:8k]
- values  in  32*MAX_SERVOS  servo k value at [32k+31:32k]; low data_len bytes sent little-endian
- busy  out  1  request accepted, packet not finished
- sending  out  1  direction enable; high while pin is driven
- pin  out  1  UART TX; idle high
- done  out  1  one-cycle pulse after the last stop bit
- error  out  1  one-cycle pulse on an illegal request

## Operation
- Reset values: busy=0, sending=0, pin=1, done=0, error=0; FSM in IDLE.
- On accept, address, data_len, servo_count, ids and values are latched. Later input changes do not affect the packet in flight.
- Illegal request (data_len ∉ 1–4, or servo_count ∉ 1–MAX_SERVOS): error pulses the next cycle; nothing is transmitted; busy stays 0.
- Byte order:
  - FF FF FD 00
  - FE (broadcast ID)
  - LEN_L LEN_H
  - 83 (instruction)
  - ADDR_L ADDR_H
  - DLEN_L DLEN_H
  - then per servo k=0..servo_count-1: ID_k followed by data_len value bytes, LSB first
  - CRC_L CRC_H
- LEN = servo_count*(1+data_len) + 7, 16-bit.
- Packet length in bytes: B = 14 + servo_count*(1+data_len).
- CRC-16: polynomial 0x8005, init 0x0000, no reflection, no final XOR. Covers every byte from the first FF through the last data byte. Updated one byte per step.
- Byte stuffing is not performed. Callers must not produce an FF FF FD sequence in parameters; this is a documented limitation.
- FSM states and transitions:
  - IDLE → HEADER (4 bytes) → PREFIX (ID, LEN, instruction, address, data length: 8 bytes) → SERVO_ID → SERVO_DATA (data_len bytes)
  - SERVO_DATA returns to SERVO_ID while servos remain; otherwise → CRC (2 bytes) → IDLE.
- UART frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts CLOCKS_PER_BIT cycles. Bytes are sent back-to-back with no idle gap.

## Timing
- Accept at cycle T: busy=1 and sending=1 from T+1; pin falls (start bit) at T+1.
- Packet occupies exactly 10·CLOCKS_PER_BIT·B cycles starting at T+1.
- In the cycle after the final stop bit ends: sending=0, busy=0, done=1.
- The next send is accepted in the cycle after done.
- send while busy=1 is ignored: no error, no queueing.
- Reset asserted mid-packet: the next cycle shows pin=1, sending=0, busy=0, no done pulse. The partial packet is abandoned.
- send asserted in the same cycle as reset: reset wins.

## Structure
- Package dynamixel_pkg holds:
  - header, broadcast ID and instruction constants (INSTR_SYNC_WRITE=8'h83)
  - function crc16_update(crc, byte) for the byte-wide combinational update
  - function for packet length
- One sub-module, uart_tx_byte: CLOCKS_PER_BIT parameter, load/ready handshake, bit counter and baud counter. The block feeds it the next byte when ready is high so there is no inter-byte gap.
- Top-level FSM owns the byte index, servo index and CRC register.

## Test plan
- CLOCKS_PER_BIT=3; address=116, data_len=4, servo_count=2; ID1 value 150, ID2 value 170 → decoded bytes FF FF FD 00 FE 11 00 83 74 00 04 00 01 96 00 00 00 02 AA 00 00 00 82 87; duration 720 cycles; done once.
- address=64, data_len=1, servo_count=4; IDs 1–4, values 1 → B=22, LEN=0x000F, CRC matches the bench reference model, only value byte 0 of each servo sent.
- data_len=0, then data_len=5, then servo_count=0 → one error pulse each; pin stays 1; sending stays 0.
- Second send mid-packet with changed values → ignored; transmitted bytes equal the first request.
- Reset asserted at byte 10 of a packet → pin=1 and sending=0 next cycle; a fresh send after reset produces a complete correct packet.
- servo_count=MAX_SERVOS, data_len=4 → B=14+5·MAX_SERVOS, no inter-byte gaps, busy is high for exactly the packet duration.
